// File: rtl/vedic_mul_seq_if.sv
// Operand/result handshake bundle for the sequential vedic multiplier.
// The producer/consumer side uses master, the multiplier uses slave.
interface vedic_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/vedic_mul_seq.sv
// Multi-cycle unsigned multiplier: four half-width Urdhva-Tiryagbhyam cross
// products, one per cycle, accumulated with shifts into a 2*WIDTH result.
module vedic_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mul_seq_if.slave   bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     product_q;
    logic [1:0]        idx_q;

    logic [H-1:0]      op_x, op_y;
    logic [2*H-1:0]    pp;
    logic [PW-1:0]     pp_ext;
    logic [PW-1:0]     pp_shifted;
    logic [PW-1:0]     sum;

    // Full-adder cell; the accumulator is a ripple chain of these.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    // Urdhva-Tiryagbhyam: each output column is the sum of all crosswise bit
    // products of that weight plus the carry rippled in from the column below.
    function automatic logic [2*H-1:0] vedic_hxh(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [2*H-1:0] r;
        logic [2*H-1:0] col;
        logic [2*H-1:0] carry;
        logic [2*H-1:0] bit_ext;
        r     = '0;
        carry = '0;
        for (int k = 0; k < 2*H-1; k++) begin
            col = carry;
            for (int i = 0; i < H; i++) begin
                if ((k - i >= 0) && (k - i < H)) begin
                    bit_ext    = '0;
                    bit_ext[0] = x[i] & y[k-i];
                    col        = col + bit_ext;
                end
            end
            r[k]  = col[0];
            carry = col >> 1;
        end
        r[2*H-1] = carry[0];
        return r;
    endfunction

    // Cross-product selection for the current step.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
        op_x       = a_q[H-1:0];
        op_y       = b_q[H-1:0];
        pp         = vedic_hxh(op_x, op_y);
        pp_ext     = '0;
        pp_shifted = '0;
        case (idx_q)
            2'd0: begin op_x = a_q[H-1:0];     op_y = b_q[H-1:0];     end
            2'd1: begin op_x = a_q[H-1:0];     op_y = b_q[WIDTH-1:H]; end
            2'd2: begin op_x = a_q[WIDTH-1:H]; op_y = b_q[H-1:0];     end
            default: begin op_x = a_q[WIDTH-1:H]; op_y = b_q[WIDTH-1:H]; end
        endcase
        pp     = vedic_hxh(op_x, op_y);
        pp_ext = {{(PW-2*H){1'b0}}, pp};
        case (idx_q)
            2'd0:    pp_shifted = pp_ext;
            2'd1,
            2'd2:    pp_shifted = pp_ext << H;
            default: pp_shifted = pp_ext << (2*H);
        endcase
    end

    // Ripple accumulate; the full product fits in PW bits so the final carry is dropped.
    always_comb begin
        logic       c;
        logic [1:0] fa;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < PW; i++) begin
            fa     = full_add(acc_q[i], pp_shifted[i], c);
            sum[i] = fa[0];
            c      = fa[1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)   state_d = S_CALC;
            S_CALC:  if (idx_q == 2'd3)  state_d = S_DONE;
            S_DONE:  if (bus.out_ready)  state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= sum;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) product_q <= sum;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; nothing combinational from inputs.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.product   = product_q;
endmodule
